// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle control sequencer for a 16-bit unpipelined ALU.
// Accepts a function code and operands over valid/ready. Drives the ALU
// controls, samples the ALU outputs and returns one result over valid/ready.
// Optional build macro ALU_OP_SEQUENCER_OFL_TRAP_EN: when it is defined,
// out_err reports the sampled ALU overflow for ADD/SUB.
module alu_op_sequencer #(
  parameter int unsigned ALU_WAIT = 0  // extra hold cycles per ALU pass (0-7)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic        alu_Cin,
  output logic [2:0]  alu_Op,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_Ofl,
  input  logic        alu_zf,
  input  logic        alu_lzf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_illegal,
  output logic        out_err
);

  localparam logic [2:0] WAIT_LAST = 3'(ALU_WAIT);

  localparam logic [3:0] F_ADD  = 4'h0;
  localparam logic [3:0] F_SUB  = 4'h1;
  localparam logic [3:0] F_SEQ  = 4'h8;
  localparam logic [3:0] F_SLT  = 4'h9;
  localparam logic [3:0] F_SLE  = 4'hA;
  localparam logic [3:0] F_SCO  = 4'hB;
  localparam logic [3:0] F_SLBI = 4'hC;

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [3:0]  func_q, func_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] data_q, data_d;
  logic        illegal_q, illegal_d;
  logic        err_q, err_d;

  // Pass-1 control decode and the flag-derived result
  logic [2:0]  op1;
  logic        inva1, invb1, cin1, sign1;
  logic [15:0] result1;
  logic        err1;

  // Decode the latched function code into first-pass ALU controls
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    op1   = 3'b000;
    inva1 = 1'b0;
    invb1 = 1'b0;
    cin1  = 1'b0;
    sign1 = 1'b0;
    case (func_q)
      F_ADD:                begin sign1 = 1'b1; end
      F_SUB:                begin inva1 = 1'b1; cin1 = 1'b1; sign1 = 1'b1; end
      4'h2:                 op1 = 3'b010;
      4'h3:                 begin op1 = 3'b011; invb1 = 1'b1; end
      4'h4:                 op1 = 3'b100;
      4'h5:                 op1 = 3'b101;
      4'h6:                 op1 = 3'b110;
      4'h7:                 op1 = 3'b001;
      F_SEQ, F_SLT, F_SLE:  begin invb1 = 1'b1; cin1 = 1'b1; sign1 = 1'b1; end
      F_SCO:                op1 = 3'b000;
      F_SLBI:               op1 = 3'b101;
      default:              ;
    endcase
  end

  // Build the single-pass result from the ALU output and flags
  always_comb begin
    result1 = alu_Out;
    case (func_q)
      F_SEQ:   result1 = {15'b0, alu_zf};
      F_SLT:   result1 = {15'b0, alu_lzf ^ alu_Ofl};
      F_SLE:   result1 = {15'b0, (alu_lzf ^ alu_Ofl) | alu_zf};
      F_SCO:   result1 = {15'b0, alu_Ofl};
      default: ;
    endcase
`ifdef ALU_OP_SEQUENCER_OFL_TRAP_EN
    err1 = ((func_q == F_ADD) || (func_q == F_SUB)) ? alu_Ofl : 1'b0;
`else
    err1 = 1'b0;
`endif
  end

  // Drive the ALU only while a pass is in flight; idle and done present zeros
  always_comb begin
    alu_A    = '0;
    alu_B    = '0;
    alu_Cin  = 1'b0;
    alu_Op   = 3'b000;
    alu_invA = 1'b0;
    alu_invB = 1'b0;
    alu_sign = 1'b0;
    case (state_q)
      S_PASS1: begin
        alu_A    = a_q;
        alu_B    = (func_q == F_SLBI) ? 16'd8 : b_q;
        alu_Cin  = cin1;
        alu_Op   = op1;
        alu_invA = inva1;
        alu_invB = invb1;
        alu_sign = sign1;
      end
      S_PASS2: begin
        alu_A  = temp_q;
        alu_B  = {8'h00, b_q[7:0]};
        alu_Op = 3'b010;
      end
      default: ;
    endcase
  end

  // Next-state logic: accept, hold each pass 1+ALU_WAIT cycles, then deliver
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    temp_d    = temp_q;
    data_d    = data_q;
    illegal_d = illegal_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          func_d = in_func;
          a_d    = in_a;
          b_d    = in_b;
          wait_d = 3'd0;
          err_d  = 1'b0;
          if (in_func > F_SLBI) begin
            // Illegal codes skip the ALU and report immediately
            data_d    = '0;
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            illegal_d = 1'b0;
            state_d   = S_PASS1;
          end
        end
      end
      S_PASS1: begin
        if (wait_q == WAIT_LAST) begin
          wait_d = 3'd0;
          if (func_q == F_SLBI) begin
            temp_d  = alu_Out;
            state_d = S_PASS2;
          end else begin
            data_d  = result1;
            err_d   = err1;
            state_d = S_DONE;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_PASS2: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 3'd0;
          data_d  = alu_Out;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= 3'd0;
      func_q    <= 4'h0;
      a_q       <= '0;
      b_q       <= '0;
      temp_q    <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      func_q    <= func_d;
      a_q       <= a_d;
      b_q       <= b_d;
      temp_q    <= temp_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
      err_q     <= err_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_data    = data_q;
  assign out_illegal = illegal_q;
`ifdef ALU_OP_SEQUENCER_OFL_TRAP_EN
  assign out_err     = err_q;
`else
  assign out_err     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: two sequencer instances (ALU_WAIT 0 and 2), each wired
// to a behavioural 16-bit ALU. Results are compared with an arithmetic
// reference computed straight from the function definitions.
module tb_alu_op_sequencer;

  localparam int NU = 2;

  typedef struct packed {
    logic [15:0] out;
    logic        ofl;
    logic        zf;
    logic        lzf;
  } alu_rsp_t;

  typedef struct packed {
    logic [15:0] data;
    logic        illegal;
    logic        err;
    logic [1:0]  passes;
    logic [2:0]  op1;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0]       rst;
  logic [NU-1:0]       in_valid;
  logic [NU-1:0]       in_ready;
  logic [NU-1:0][3:0]  in_func;
  logic [NU-1:0][15:0] in_a, in_b;
  logic [NU-1:0][15:0] alu_A, alu_B;
  logic [NU-1:0]       alu_Cin, alu_invA, alu_invB, alu_sign;
  logic [NU-1:0][2:0]  alu_Op;
  alu_rsp_t [NU-1:0]   alu_rsp;
  logic [NU-1:0]       out_valid, out_ready, out_illegal, out_err;
  logic [NU-1:0][15:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural ALU: operand inversion, adder with carry-in, logic and shifts
  function automatic alu_rsp_t alu_eval(input logic [15:0] a_in, input logic [15:0] b_in,
                                        input logic cin, input logic [2:0] op,
                                        input logic inva, input logic invb, input logic sgn);
    alu_rsp_t r;
    logic [15:0] x, y;
    logic [16:0] s;
    logic [31:0] d;
    logic [3:0]  sh;
    x = inva ? ~a_in : a_in;
    y = invb ? ~b_in : b_in;
    sh = y[3:0];
    s = {1'b0, x} + {1'b0, y} + {16'b0, cin};
    r = '0;
    case (op)
      3'b000: begin
        r.out = s[15:0];
        r.ofl = sgn ? ((x[15] == y[15]) && (s[15] != x[15])) : s[16];
      end
      3'b001: r.out = x >> sh;
      3'b010: r.out = x ^ y;
      3'b011: r.out = x & y;
      3'b100: begin d = {x, x} << sh; r.out = d[31:16]; end
      3'b101: r.out = x << sh;
      3'b110: begin d = {x, x} >> sh; r.out = d[15:0]; end
      default: r.out = '0;
    endcase
    r.zf  = (r.out == 16'h0000);
    r.lzf = r.out[15];
    return r;
  endfunction

  for (genvar g = 0; g < NU; g++) begin : g_u
    assign alu_rsp[g] = alu_eval(alu_A[g], alu_B[g], alu_Cin[g], alu_Op[g],
                                 alu_invA[g], alu_invB[g], alu_sign[g]);
    alu_op_sequencer #(.ALU_WAIT((g == 0) ? 0 : 2)) dut (
      .clk         (clk),
      .rst         (rst[g]),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in_func     (in_func[g]),
      .in_a        (in_a[g]),
      .in_b        (in_b[g]),
      .alu_A       (alu_A[g]),
      .alu_B       (alu_B[g]),
      .alu_Cin     (alu_Cin[g]),
      .alu_Op      (alu_Op[g]),
      .alu_invA    (alu_invA[g]),
      .alu_invB    (alu_invB[g]),
      .alu_sign    (alu_sign[g]),
      .alu_Out     (alu_rsp[g].out),
      .alu_Ofl     (alu_rsp[g].ofl),
      .alu_zf      (alu_rsp[g].zf),
      .alu_lzf     (alu_rsp[g].lzf),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready[g]),
      .out_data    (out_data[g]),
      .out_illegal (out_illegal[g]),
      .out_err     (out_err[g])
    );
  end

  // Reference: what each function code means, in plain arithmetic
  function automatic exp_t ref_model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int sa, sb, sr;
    logic [16:0] wide;
    logic [31:0] dbl;
    logic [3:0]  sh;
    e = '0;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[3:0];
    e.passes = 2'd1;
    case (f)
      4'h0: begin e.data = a + b; sr = sa + sb; e.err = (sr > 32767) || (sr < -32768); e.op1 = 3'b000; end
      4'h1: begin e.data = b - a; sr = sb - sa; e.err = (sr > 32767) || (sr < -32768); e.op1 = 3'b000; end
      4'h2: begin e.data = a ^ b;  e.op1 = 3'b010; end
      4'h3: begin e.data = a & ~b; e.op1 = 3'b011; end
      4'h4: begin dbl = {a, a} << sh; e.data = dbl[31:16]; e.op1 = 3'b100; end
      4'h5: begin e.data = a << sh; e.op1 = 3'b101; end
      4'h6: begin dbl = {a, a} >> sh; e.data = dbl[15:0]; e.op1 = 3'b110; end
      4'h7: begin e.data = a >> sh; e.op1 = 3'b001; end
      4'h8: begin e.data = {15'b0, a == b}; e.op1 = 3'b000; end
      4'h9: begin e.data = {15'b0, sa < sb}; e.op1 = 3'b000; end
      4'hA: begin e.data = {15'b0, sa <= sb}; e.op1 = 3'b000; end
      4'hB: begin wide = {1'b0, a} + {1'b0, b}; e.data = {15'b0, wide[16]}; e.op1 = 3'b000; end
      4'hC: begin e.data = {a[7:0], b[7:0]}; e.passes = 2'd2; e.op1 = 3'b101; end
      default: begin e.data = '0; e.illegal = 1'b1; e.passes = 2'd0; end
    endcase
`ifndef ALU_OP_SEQUENCER_OFL_TRAP_EN
    e.err = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int u, input string tag);
    check({tag, "_alu"}, {alu_A[u], alu_B[u], alu_Cin[u], alu_Op[u], alu_invA[u], alu_invB[u], alu_sign[u]} == '0, 1);
    check({tag, "_outs"}, {out_valid[u], out_data[u], out_illegal[u], out_err[u]}, 0);
    check({tag, "_in_ready"}, in_ready[u], 1);
  endtask

  task automatic wait_ready(input int u, input string tag);
    int n = 0;
    while (in_ready[u] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, in_ready[u], 1);
  endtask

  // One full transaction; called and returning on a negedge
  task automatic do_op(input int u, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input bit hold, input string tag);
    exp_t e;
    int edges, w, exp_edges;
    logic [2:0] first_op, last_op;
    bit busy_ready_bad;
    e = ref_model(f, a, b);
    w = (u == 0) ? 0 : 2;
    exp_edges = (e.passes == 0) ? 0 : (e.passes == 1) ? 1 + w : 2 + 2 * w;
    wait_ready(u, tag);
    if (hold) out_ready[u] = 1'b0;
    in_valid[u] = 1'b1; in_func[u] = f; in_a[u] = a; in_b[u] = b;
    @(posedge clk);
    @(negedge clk);
    // Keep in_valid high with junk while busy: it must be ignored
    in_a[u] = 16'($urandom); in_b[u] = 16'($urandom); in_func[u] = 4'($urandom);
    edges = 0; busy_ready_bad = 1'b0;
    first_op = alu_Op[u]; last_op = alu_Op[u];
    while (out_valid[u] !== 1'b1 && edges < 40) begin
      if (in_ready[u] !== 1'b0) busy_ready_bad = 1'b1;
      last_op = alu_Op[u];
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, edges, exp_edges);
    check({tag, "_data"}, out_data[u], e.data);
    check({tag, "_illegal"}, out_illegal[u], e.illegal);
    check({tag, "_err"}, out_err[u], e.err);
    check({tag, "_busy_ready"}, busy_ready_bad, 0);
    check({tag, "_done_alu"}, {alu_A[u], alu_Op[u]}, 0);
    if (e.passes != 0) begin
      check({tag, "_op1"}, first_op, e.op1);
      check({tag, "_oplast"}, last_op, (e.passes == 2) ? 3'b010 : e.op1);
    end
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hold_data"}, out_data[u], e.data);
        check({tag, "_hold_flags"}, {out_valid[u], out_illegal[u], out_err[u], in_ready[u]},
              {1'b1, e.illegal, e.err, 1'b0});
      end
      out_ready[u] = 1'b1;
    end
    // Handoff edge: in_valid is still high but must not be accepted here
    @(posedge clk);
    @(negedge clk);
    check({tag, "_handoff"}, {in_ready[u], out_valid[u]}, 2'b10);
    in_valid[u] = 1'b0;
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = '1; in_valid = '0; out_ready = '1;
    in_func = '0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = '0;
    check_reset(0, "reset_u0");
    check_reset(1, "reset_u1");

    // Directed cases on the zero-wait instance
    do_op(0, 4'h0, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
    do_op(0, 4'h9, 16'h8000, 16'h0001, 1'b0, "slt");
    do_op(0, 4'hA, 16'h1234, 16'h1234, 1'b0, "sle_eq");
    do_op(0, 4'h8, 16'h0001, 16'h0002, 1'b0, "seq_ne");
    do_op(0, 4'hB, 16'hFFFF, 16'h0001, 1'b0, "sco");
    do_op(0, 4'h1, 16'h0003, 16'h000A, 1'b0, "sub");

    // Two-pass SLBI with ALU_WAIT=2
    do_op(1, 4'hC, 16'h12AB, 16'h00CD, 1'b0, "slbi_w2");

    // Backpressure, then an illegal code
    do_op(0, 4'h3, 16'hF0F0, 16'h0FF0, 1'b1, "andn_hold");
    do_op(0, 4'hE, 16'h1111, 16'h2222, 1'b1, "illegal_hold");

    // Reset in the middle of SLBI pass 2
    wait_ready(1, "rst_mid");
    in_valid[1] = 1'b1; in_func[1] = 4'hC; in_a[1] = 16'h12AB; in_b[1] = 16'h00CD;
    @(posedge clk);
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("rst_mid_pass2_op", alu_Op[1], 3'b010);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    check_reset(1, "rst_mid");
    do_op(1, 4'h0, 16'h0002, 16'h0003, 1'b0, "add_after_rst");

    // Randomized traffic on both instances, occasionally with backpressure
    for (int i = 0; i < 40; i++) begin
      do_op($urandom_range(0, 1), 4'($urandom_range(0, 15)), pick_val(), pick_val(),
            ($urandom_range(0, 7) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle ALU control sequencer for the 16-bit unpipelined datapath.
- Accepts an ALU function code plus operands over a valid/ready handshake and drives the ALU control inputs: A, B, Cin, Op, invA, invB, sign.
- Samples the ALU's Out, Ofl and flag outputs, then returns one result over a valid/ready handshake.
- Compare and set ops are built from ALU flags; SLBI takes two ALU passes through a temp register.

Parameters:
- ALU_WAIT, 0: extra hold cycles per ALU pass before sampling ALU outputs (0–7), for timing margin.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  sequencer can accept
- in_func  in  4  function code
- in_a  in  16  operand A (Rs)
- in_b  in  16  operand B (Rt or immediate)
- alu_A  out  16  ALU A
- alu_B  out  16  ALU B
- alu_Cin  out  1  ALU carry-in
- alu_Op  out  3  ALU op
- alu_invA  out  1  invert A
- alu_invB  out  1  invert B
- alu_sign  out  1  signed mode
- alu_Out  in  16  ALU result
- alu_Ofl  in  1  ALU overflow/carry
- alu_zf  in  1  ALU zero flag
- alu_lzf  in  1  ALU less-than-zero flag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_data  out  16  result
- out_illegal  out  1  func code was illegal
- out_err  out  1  signed overflow (see Optional Feature)

Behaviour:
- Reset: clk and rst are the sole clock and reset; rst is synchronous and active-high.
  - State IDLE, wait counter 0, temp 0.
  - All alu_* outputs 0, out_valid 0, out_data 0, out_illegal 0, out_err 0.
  - in_ready 1 from the first cycle after rst deasserts.
- ALU op map:
  - 000 add; 001 logical shift right (raw A/B).
  - 010 xor; 011 and.
  - 100 rotate left; 101 shift left; 110 rotate right; 111 reserved.
  - Shift count is B[3:0].
- Func map (alu_Op / invA / invB / Cin / sign):
  - 0 ADD A+B: 000 / 0 / 0 / 0 / 1.
  - 1 SUB B−A: 000 / 1 / 0 / 1 / 1.
  - 2 XOR: 010 / 0 / 0 / 0 / 0.
  - 3 ANDN A&~B: 011 / 0 / 1 / 0 / 0.
  - 4 ROL: 100. 5 SLL: 101. 6 ROR: 110. 7 SRL: 001. All with invA/invB/Cin/sign 0.
  - 8 SEQ, 9 SLT, A SLE: A−B as 000 / 0 / 1 / 1 / 1.
  - B SCO: A+B as 000 / 0 / 0 / 0 / 0.
  - C SLBI: two passes (see below).
  - D–F: illegal.
- States:
  - IDLE: in_ready=1. On in_valid, latch func and operands → PASS1.
  - PASS1: alu_* driven from registers; hold 1+ALU_WAIT cycles, then sample ALU outputs.
    - SLBI: temp←alu_Out → PASS2.
    - All other funcs → DONE.
  - PASS2 (SLBI only): alu_A=temp, alu_B={8'h00,in_b[7:0]}, alu_Op=010. Hold 1+ALU_WAIT cycles, sample → DONE.
  - DONE: out_valid=1, outputs stable. On out_ready → IDLE; in_ready returns 1 the next cycle.
- SLBI pass 1: alu_A=in_a, alu_B=16'd8, alu_Op=101.
- Result rules:
  - SEQ = {15'b0, zf}.
  - SLT = {15'b0, lzf^Ofl}.
  - SLE = {15'b0, (lzf^Ofl)|zf}.
  - SCO = {15'b0, Ofl}.
  - All others = alu_Out.
- Illegal func: skips PASS1. Goes IDLE→DONE in one cycle with out_data=0, out_illegal=1.
- Latency: accept at edge k; out_valid is high after edge k+1+ALU_WAIT (single pass) or k+2+2·ALU_WAIT (SLBI).
- alu_* outputs return to 0 in IDLE and DONE.
- Boundary conditions:
  - in_ready=0 in every non-IDLE state; in_valid is ignored there.
  - No back-to-back accept in the same cycle as a DONE handoff.
  - rst in any state (including mid-PASS2 or DONE with out_ready low) discards the op; next cycle matches post-reset values.
  - out_ready held low: result, out_illegal and out_err stay stable indefinitely.

Optional Feature:
- Macro ALU_OP_SEQUENCER_OFL_TRAP_EN.
- Defined: out_err = alu_Ofl sampled for ADD/SUB; 0 for every other func. Result is still delivered.
- Undefined: out_err is constant 0.

Test Plan:
- Reset then ADD a=0x7FFF b=0x0001, ALU_WAIT=0, out_ready=1 → out_data=0x8000, out_valid one edge after PASS1. out_err=1 with macro, 0 without.
- SLT a=0x8000 b=0x0001 → out_data=0x0001 (Ofl=1, lzf=0). SLE a=b=0x1234 → 0x0001. SEQ a=0x0001 b=0x0002 → 0x0000.
- SCO a=0xFFFF b=0x0001 → 0x0001. SUB a=0x0003 b=0x000A → 0x0007.
- SLBI a=0x12AB b=0x00CD, ALU_WAIT=2 → out_data=0xABCD; out_valid high after edge k+6; alu_Op observed 101 then 010.
- Backpressure: out_ready=0 for 5 cycles after out_valid → data stable, in_ready=0. Raise out_ready → in_ready=1 the next cycle. func=0xE → out_illegal=1, out_data=0.
- rst asserted during SLBI PASS2 → next cycle out_valid=0, alu_* all 0, in_ready=1; a following ADD 2+3 → 0x0005.
